// File: rtl/shm_column_scroller.sv
// Column FIFO feeding a 17x7 scrolling frame; each step shifts one column in at the right
// edge and hands the frame to the I2C updater over a valid/ack handshake.
//
// state     | meaning
// S_RUN     | idle, waiting for a pending scroll step
// S_SHIFT   | single cycle: shift frame left, load popped column, raise frame_valid
// S_PRESENT | frame held stable until the updater acks it
module shm_column_scroller #(
  parameter int FIFO_DEPTH = 8,
  parameter int STEP_DIV   = 5_000_000,
  parameter int NUM_COLS   = 17,
  parameter int NUM_ROWS   = 7
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_ROWS-1:0]                  col_data,
  input  logic                                 col_valid,
  output logic                                 col_ready,
  input  logic                                 enable,
  input  logic                                 clear,
  output logic [NUM_COLS*NUM_ROWS-1:0]         frame,
  output logic                                 frame_valid,
  input  logic                                 frame_ack,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
  output logic                                 underrun
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = $clog2(FIFO_DEPTH+1);
  localparam int TMR_W   = $clog2(STEP_DIV);
  localparam int FRAME_W = NUM_COLS*NUM_ROWS;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_DIV-1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_SHIFT   = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  logic [NUM_ROWS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [1:0]          state;
  logic [TMR_W-1:0]    timer;
  logic                step_pending;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic                tc;
  logic [NUM_ROWS-1:0] shift_col;
  logic [FRAME_W-1:0]  frame_shifted;

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_FULL);
  assign col_ready  = !fifo_full && !reset;
  assign push       = col_valid && col_ready && !clear;
  assign pop        = (state == S_SHIFT) && !fifo_empty && !clear;
  assign tc         = enable && (timer == TMR_LAST);
  assign shift_col  = fifo_empty ? '0 : mem[rd_ptr];

  // Bit layout is col + NUM_COLS*row, so a left shift moves each row's bits down by one.
  always_comb begin
    frame_shifted = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS-1; c++) begin
        frame_shifted[c + NUM_COLS*r] = frame[c + 1 + NUM_COLS*r];
      end
      frame_shifted[NUM_COLS-1 + NUM_COLS*r] = shift_col[r];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= col_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      timer        <= '0;
      step_pending <= 1'b0;
      state        <= S_RUN;
      frame        <= '0;
      frame_valid  <= 1'b0;
      underrun     <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      timer        <= '0;
      step_pending <= 1'b0;
      state        <= S_PRESENT;
      frame        <= '0;
      frame_valid  <= 1'b1;
      underrun     <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        fifo_level <= fifo_level + LVL_W'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LVL_W'(1);
      end

      // A terminal count landing on the shift cycle is a fresh step and survives the consume.
      if (!enable) begin
        timer        <= '0;
        step_pending <= 1'b0;
      end else begin
        timer <= tc ? '0 : timer + TMR_W'(1);
        if (tc) begin
          step_pending <= 1'b1;
        end else if (state == S_SHIFT) begin
          step_pending <= 1'b0;
        end
      end

      case (state)
        S_RUN: begin
          if (step_pending) state <= S_SHIFT;
        end
        S_SHIFT: begin
          frame       <= frame_shifted;
          frame_valid <= 1'b1;
          underrun    <= fifo_empty;
          state       <= S_PRESENT;
        end
        S_PRESENT: begin
          if (frame_ack) begin
            frame_valid <= 1'b0;
            state       <= step_pending ? S_SHIFT : S_RUN;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule
